// File: rtl/hilo_muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl_pkg
// Shared CPU-side definitions for the HI/LO multiply/divide controller:
//   muldiv_op_t     - operation code presented by the execute stage
//   muldiv_state_t  - controller FSM state (also exported for debug)
//   DIV_ITERS       - number of restoring-division iterations
//   abs32()         - two's-complement magnitude helper
// ---------------------------------------------------------------------------
package hilo_muldiv_ctrl_pkg;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;
    // Counter value of the write-back cycle that follows the last iteration.
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS);

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } muldiv_state_t;

    // Magnitude of v when treated as signed; raw v otherwise.
    // |0x80000000| stays 0x80000000, which is correct as an unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl_if
// Execute-stage <-> HI/LO unit bus.
//   req, op, a, b, flush : driven by the execute stage (master)
//   busy, hi, lo         : driven by the HI/LO unit (slave)
// Handshake: a request is taken on a rising clk edge when req=1, flush=0,
// op!=NOP and busy=0 (unit idle). While busy=1 the unit ignores req/op/a/b;
// the pipeline holds the instruction stalled until busy falls.
// ---------------------------------------------------------------------------
interface hilo_muldiv_ctrl_if;

    logic                              req;
    hilo_muldiv_ctrl_pkg::muldiv_op_t  op;
    logic [31:0]                       a;
    logic [31:0]                       b;
    logic                              flush;
    logic                              busy;
    logic [31:0]                       hi;
    logic [31:0]                       lo;

    modport master (output req, op, a, b, flush, input busy, hi, lo);
    modport slave  (input req, op, a, b, flush, output busy, hi, lo);

endinterface

// File: rtl/hilo_muldiv_ctrl_mult.sv
// ---------------------------------------------------------------------------
// Execute_MULT
// Unsigned 32x32 -> 64 multiplier with a valid/done handshake.
// Two-cycle operation: operands are taken in the cycle i_valid=1, and the
// product is presented with o_done=1 in the following cycle.
//   clk, resetn : clock, synchronous active-low reset
//   i_valid     : start pulse, operands i_a/i_b sampled with it
//   o_done      : one-cycle pulse, o_prod valid while high
//   o_prod      : 64-bit unsigned product
// ---------------------------------------------------------------------------
module Execute_MULT (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_done,
    output logic [63:0] o_prod
);

    logic        r_done;
    logic [63:0] r_prod;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_done <= 1'b0;
            r_prod <= '0;
        end else begin
            r_done <= i_valid;
            if (i_valid) begin
                r_prod <= {32'd0, i_a} * {32'd0, i_b};
            end
        end
    end

    assign o_done = r_done;
    assign o_prod = r_prod;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl
// HI/LO register unit: MULT/MULTU via Execute_MULT, DIV/DIVU via an internal
// 32-iteration restoring divider, MTHI/MTLO single-cycle writes.
//   clk, resetn  : clock, synchronous active-low reset
//   bus (slave)  : req/op/a/b/flush in, busy/hi/lo out
//   o_dbg_state  : current FSM state, for observation only
// Parameter DIV0_KEEP: 1 = divide by zero leaves HI/LO alone,
//                      0 = divide by zero writes HI=a, LO=all ones.
// ---------------------------------------------------------------------------
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DIV0_KEEP = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    hilo_muldiv_ctrl_if.slave      bus,
    output muldiv_state_t          o_dbg_state
);

    muldiv_state_t     r_state;
    muldiv_state_t     w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_opa;     // MUL: |a|; DIV: dividend shifting into quotient
    logic [31:0]       r_opb;     // |b| (multiplier operand or divisor)
    logic [31:0]       r_rem;     // partial remainder
    logic              r_sign_q;  // product / quotient negate
    logic              r_sign_r;  // remainder negate (sign of dividend)
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;

    logic              w_accept;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_signed;
    logic              w_b_zero;
    logic              w_mul_valid;
    logic              w_mul_done;
    logic [63:0]       w_prod;
    logic [63:0]       w_prod_fix;
    logic [32:0]       w_shift;
    logic [32:0]       w_diff;
    logic              w_ge;
    logic [31:0]       w_rem_nxt;
    logic [31:0]       w_quo_nxt;
    logic [31:0]       w_quo_fix;
    logic [31:0]       w_rem_fix;

    assign w_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_b_zero = (bus.b == 32'd0);
    assign w_accept = bus.req && !bus.flush && (r_state == S_IDLE) && (bus.op != OP_NOP);

    Execute_MULT u_mult (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (w_mul_valid),
        .i_a     (r_opa),
        .i_b     (r_opb),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );

    // One restoring step: shift next dividend bit into the remainder and
    // subtract the divisor if it fits (33-bit difference, bit 32 = borrow).
    assign w_shift   = {r_rem, r_opa[31]};
    assign w_diff    = w_shift - {1'b0, r_opb};
    assign w_ge      = !w_diff[32];
    assign w_rem_nxt = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nxt = {r_opa[30:0], w_ge};

    assign w_prod_fix = r_sign_q ? (~w_prod + 64'd1) : w_prod;
    assign w_quo_fix  = r_sign_q ? (~r_opa + 32'd1) : r_opa;
    assign w_rem_fix  = r_sign_r ? (~r_rem + 32'd1) : r_rem;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and multiplier start
    always_comb begin
        w_state_nxt = r_state;
        w_mul_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt = S_MUL;
                    end else if (w_is_div && !w_b_zero) begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: begin
                // Counter is 0 only in the first MUL cycle.
                w_mul_valid = (r_cnt == '0);
                if (w_mul_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                if (r_cnt == DIV_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath: counter, operands, partial remainder, HI/LO
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_rem    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            if ((r_state == S_IDLE) || (w_state_nxt == S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept && (w_is_mul || (w_is_div && !w_b_zero))) begin
                r_opa    <= abs32(bus.a, w_signed);
                r_opb    <= abs32(bus.b, w_signed);
                r_sign_q <= w_signed & (bus.a[31] ^ bus.b[31]);
                r_sign_r <= w_signed & bus.a[31];
                r_rem    <= '0;
            end else if (bus.flush) begin
                r_rem <= '0;
            end else if ((r_state == S_DIV) && (r_cnt != DIV_LAST)) begin
                r_opa <= w_quo_nxt;
                r_rem <= w_rem_nxt;
            end

            // HI/LO writes; flush suppresses every one of them.
            if (!bus.flush) begin
                if (w_accept) begin
                    case (bus.op)
                        OP_MTHI: r_hi <= bus.a;
                        OP_MTLO: r_lo <= bus.a;
                        OP_DIV, OP_DIVU: begin
                            if (w_b_zero && (DIV0_KEEP == 0)) begin
                                r_hi <= bus.a;
                                r_lo <= 32'hFFFF_FFFF;
                            end
                        end
                        default: ;
                    endcase
                end else if ((r_state == S_MUL) && w_mul_done) begin
                    r_hi <= w_prod_fix[63:32];
                    r_lo <= w_prod_fix[31:0];
                end else if ((r_state == S_DIV) && (r_cnt == DIV_LAST)) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
            end
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
// Directed bench for hilo_muldiv_ctrl. u_dut uses DIV0_KEEP=1, u_dut0 uses
// DIV0_KEEP=0. Inputs change 1 time unit after the rising edge; outputs are
// read at the same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    hilo_muldiv_ctrl_if bus();
    hilo_muldiv_ctrl_if bus0();
    muldiv_state_t dbg_state;
    muldiv_state_t dbg_state0;

    hilo_muldiv_ctrl #(.DIV0_KEEP(1)) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    hilo_muldiv_ctrl #(.DIV0_KEEP(0)) u_dut0 (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus0),
        .o_dbg_state (dbg_state0)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle, then drop it and change a/b so the
    // unit must work from its latched copies. Returns busy cycle count.
    task automatic run_op(input muldiv_op_t op, input logic [31:0] a,
                          input logic [31:0] b, output int nbusy);
        bus.req = 1'b1;
        bus.op  = op;
        bus.a   = a;
        bus.b   = b;
        cyc();
        bus.req = 1'b0;
        bus.op  = OP_NOP;
        bus.a   = 32'hA5A5_A5A5;
        bus.b   = 32'h5A5A_5A5A;
        nbusy   = 0;
        while (bus.busy === 1'b1 && nbusy < 100) begin
            nbusy++;
            cyc();
        end
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        int nb;
        run_op(OP_MTHI, h, 32'd0, nb);
        run_op(OP_MTLO, l, 32'd0, nb);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) cyc();
        n_tests++;
        if (bus.busy !== 1'b0 || dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_busy: busy=%b state=%0d expected busy=0 state=0", bus.busy, dbg_state);
        end
        n_tests++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", bus.hi, bus.lo);
        end
        resetn = 1'b1;
        cyc();
    endtask

    task automatic test_mul();
        int nb;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, nb);
        n_tests++;
        if (nb != 2 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
            n_fail++;
            $display("FAIL mult_neg3x5: busy=%0d hi=%h lo=%h expected 2 ffffffff fffffff1", nb, bus.hi, bus.lo);
        end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
        n_tests++;
        if (nb != 2 || bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_max: busy=%0d hi=%h lo=%h expected 2 fffffffe 00000001", nb, bus.hi, bus.lo);
        end
        run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, nb);
        n_tests++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_7xneg3: hi=%h lo=%h expected ffffffff ffffffeb", bus.hi, bus.lo);
        end
        run_op(OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, nb);
        n_tests++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd20) begin
            n_fail++;
            $display("FAIL mult_neg4xneg5: hi=%h lo=%h expected 0 14", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        int nb;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb);
        n_tests++;
        if (nb != 33 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_neg7_2: busy=%0d hi=%h lo=%h expected 33 ffffffff fffffffd", nb, bus.hi, bus.lo);
        end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        n_tests++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            n_fail++;
            $display("FAIL div_min_neg1: hi=%h lo=%h expected 0 80000000", bus.hi, bus.lo);
        end
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, nb);
        n_tests++;
        if (bus.lo !== 32'h0FFF_FFFF || bus.hi !== 32'hF) begin
            n_fail++;
            $display("FAIL divu_max_16: hi=%h lo=%h expected f 0fffffff", bus.hi, bus.lo);
        end
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, nb);
        n_tests++;
        if (bus.lo !== 32'hFFFF_FFF2 || bus.hi !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL div_neg100_7: hi=%h lo=%h expected fffffffe fffffff2", bus.hi, bus.lo);
        end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, nb);
        n_tests++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'd1) begin
            n_fail++;
            $display("FAIL div_7_neg2: hi=%h lo=%h expected 1 fffffffd", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div0();
        int nb;
        set_hilo(32'h1111_2222, 32'h3333_4444);
        run_op(OP_DIVU, 32'd100, 32'd0, nb);
        n_tests++;
        if (nb != 0 || bus.hi !== 32'h1111_2222 || bus.lo !== 32'h3333_4444) begin
            n_fail++;
            $display("FAIL divu_by0_keep: busy=%0d hi=%h lo=%h expected 0 11112222 33334444", nb, bus.hi, bus.lo);
        end
        // DIV0_KEEP=0 instance
        bus0.req = 1'b1;
        bus0.op  = OP_DIV;
        bus0.a   = 32'h0000_0055;
        bus0.b   = 32'd0;
        cyc();
        bus0.req = 1'b0;
        bus0.op  = OP_NOP;
        n_tests++;
        if (bus0.busy !== 1'b0 || bus0.hi !== 32'h55 || bus0.lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_by0_write: busy=%b hi=%h lo=%h expected 0 00000055 ffffffff", bus0.busy, bus0.hi, bus0.lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        int nb;
        run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, nb);
        n_tests++;
        if (nb != 0 || bus.hi !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL mthi: busy=%0d hi=%h expected 0 deadbeef", nb, bus.hi);
        end
        run_op(OP_MTLO, 32'hCAFE_F00D, 32'd0, nb);
        n_tests++;
        if (nb != 0 || bus.lo !== 32'hCAFE_F00D || bus.hi !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL mtlo: busy=%0d hi=%h lo=%h expected 0 deadbeef cafef00d", nb, bus.hi, bus.lo);
        end
    endtask

    task automatic test_flush_div();
        set_hilo(32'hAAAA_0001, 32'hBBBB_0002);
        bus.req = 1'b1;
        bus.op  = OP_DIV;
        bus.a   = 32'd100;
        bus.b   = 32'd7;
        cyc();
        bus.req = 1'b0;
        bus.op  = OP_NOP;
        repeat (9) cyc();           // now in DIV cycle 10
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL flush_div_busy: busy=%b state=%0d expected 0 0", bus.busy, dbg_state);
        end
        repeat (40) cyc();
        n_tests++;
        if (bus.hi !== 32'hAAAA_0001 || bus.lo !== 32'hBBBB_0002) begin
            n_fail++;
            $display("FAIL flush_div_hilo: hi=%h lo=%h expected aaaa0001 bbbb0002", bus.hi, bus.lo);
        end
        bus.req = 1'b1;
        bus.op  = OP_MTLO;
        bus.a   = 32'h1234;
        cyc();
        bus.req = 1'b0;
        bus.op  = OP_NOP;
        n_tests++;
        if (bus.lo !== 32'h1234 || bus.hi !== 32'hAAAA_0001) begin
            n_fail++;
            $display("FAIL flush_then_mtlo: hi=%h lo=%h expected aaaa0001 00001234", bus.hi, bus.lo);
        end
    endtask

    task automatic test_flush_priority();
        set_hilo(32'h0000_00C1, 32'h0000_00C2);
        // flush together with a request: not accepted
        bus.req   = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'hBAD0_BAD0;
        bus.flush = 1'b1;
        cyc();
        bus.req   = 1'b0;
        bus.op    = OP_NOP;
        bus.flush = 1'b0;
        n_tests++;
        if (bus.hi !== 32'h0000_00C1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_vs_req: hi=%h busy=%b expected 000000c1 0", bus.hi, bus.busy);
        end
        // flush in the multiplier completion cycle: no write
        bus.req = 1'b1;
        bus.op  = OP_MULT;
        bus.a   = 32'd3;
        bus.b   = 32'd5;
        cyc();                      // MUL cycle 1
        bus.req = 1'b0;
        bus.op  = OP_NOP;
        cyc();                      // MUL cycle 2 (done)
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        repeat (3) cyc();
        n_tests++;
        if (bus.hi !== 32'h0000_00C1 || bus.lo !== 32'h0000_00C2 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_vs_done: hi=%h lo=%h busy=%b expected 000000c1 000000c2 0", bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_ignore_while_busy();
        int nb;
        bus.req = 1'b1;
        bus.op  = OP_DIVU;
        bus.a   = 32'd100;
        bus.b   = 32'd7;
        cyc();
        bus.op  = OP_MTHI;          // req held high with a different op
        bus.a   = 32'hBAD0_0BAD;
        bus.b   = 32'd0;
        repeat (20) cyc();
        bus.req = 1'b0;
        bus.op  = OP_NOP;
        nb = 0;
        while (bus.busy === 1'b1 && nb < 100) begin
            nb++;
            cyc();
        end
        n_tests++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            n_fail++;
            $display("FAIL ignore_while_busy: hi=%h lo=%h expected 00000002 0000000e", bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        run_op(OP_MTHI, 32'h11, 32'd0, nb);
        run_op(OP_MTLO, 32'h22, 32'd0, nb);
        n_tests++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            n_fail++;
            $display("FAIL b2b_mt: hi=%h lo=%h expected 00000011 00000022", bus.hi, bus.lo);
        end
        run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, nb);
        n_tests++;
        if (nb != 2 || bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_multu: busy=%0d hi=%h lo=%h expected 2 00000001 00000000", nb, bus.hi, bus.lo);
        end
        run_op(OP_DIVU, 32'd100, 32'd7, nb);
        n_tests++;
        if (nb != 33 || bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
            n_fail++;
            $display("FAIL b2b_divu: busy=%0d hi=%h lo=%h expected 33 00000002 0000000e", nb, bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_midop();
        set_hilo(32'h5, 32'h6);
        bus.req = 1'b1;
        bus.op  = OP_DIV;
        bus.a   = 32'd1000;
        bus.b   = 32'd3;
        cyc();
        bus.req = 1'b0;
        bus.op  = OP_NOP;
        repeat (5) cyc();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        n_tests++;
        if (bus.busy !== 1'b0 || dbg_state !== S_IDLE || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_midop: busy=%b state=%0d hi=%h lo=%h expected 0 0 0 0", bus.busy, dbg_state, bus.hi, bus.lo);
        end
        repeat (40) cyc();
        n_tests++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_midop_late: hi=%h lo=%h expected 0 0", bus.hi, bus.lo);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_tests   = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        bus.req   = 1'b0;
        bus.op    = OP_NOP;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        bus0.req   = 1'b0;
        bus0.op    = OP_NOP;
        bus0.a     = '0;
        bus0.b     = '0;
        bus0.flush = 1'b0;

        test_reset();
        test_mul();
        test_div();
        test_div0();
        test_mthi_mtlo();
        test_flush_div();
        test_flush_priority();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_midop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
